// File: rtl/pes_mul_pkg.sv
// Shared definitions for the multiplier arbiter and the multiplier wrapper:
// default sizes, the requester tag carried beside the multiplier pipeline.
package pes_mul_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int DATA_W_DEF  = 32;
  localparam int MUL_LAT_DEF = 4;
  localparam int TAG_W       = $clog2(NREQ_DEF);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] id;
  } tag_t;

  // Counter width able to hold MUL_LAT+1 outstanding operations.
  function automatic int inflight_w(input int lat);
    return $clog2(lat + 2);
  endfunction

endpackage

// File: rtl/pes_mul_arbiter_if.sv
// Requester, response and multiplier-side signals of pes_mul_arbiter.
// slave = arbiter side, master = the environment (requesters + multiplier).
interface pes_mul_arbiter_if
  import pes_mul_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
);
  localparam int INF_W = inflight_w(MUL_LAT);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*DATA_W-1:0] req_a;
  logic [NREQ*DATA_W-1:0] req_b;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_data;
  logic [DATA_W-1:0]      mul_a;
  logic [DATA_W-1:0]      mul_b;
  logic [DATA_W-1:0]      mul_f;
  logic [INF_W-1:0]       inflight;

  modport slave (
    input  req_valid, req_a, req_b, mul_f,
    output req_ready, rsp_valid, rsp_data, mul_a, mul_b, inflight
  );

  modport master (
    output req_valid, req_a, req_b, mul_f,
    input  req_ready, rsp_valid, rsp_data, mul_a, mul_b, inflight
  );

endinterface

// File: rtl/pes_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr (wrapping), returned
// as a one-hot grant plus its index.
module pes_rr_arbiter
  import pes_mul_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]  req,
  input  logic [TAG_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [TAG_W-1:0] idx,
  output logic             any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      logic [TAG_W-1:0] sel;
      sel = TAG_W'((int'(ptr) + off) % NREQ);
      if (!any && req[sel]) begin
        any = 1'b1;
        idx = sel;
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/pes_mul_arbiter.sv
// Shares one fixed-latency pipelined multiplier between NREQ requesters and
// routes each product back to its issuer. Option: PES_MULARB_PRIO0_EN.
module pes_mul_arbiter
  import pes_mul_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input logic              clk,
  input logic              rst,
  pes_mul_arbiter_if.slave bus
);

  localparam int INF_W = inflight_w(MUL_LAT);

  logic [NREQ-1:0]   rr_req, rr_grant, grant, rsp_vec;
  logic [TAG_W-1:0]  rr_idx, gidx, ptr_reg;
  logic              rr_any, any, hs, adv_ptr, rsp_hit;
  logic [DATA_W-1:0] sel_a, sel_b, mul_a_reg, mul_b_reg;
  logic [INF_W-1:0]  inflight_reg;
  tag_t              tag_reg [MUL_LAT+1];
  tag_t              last;

  pes_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (rr_req),
    .ptr   (ptr_reg),
    .grant (rr_grant),
    .idx   (rr_idx),
    .any   (rr_any)
  );

`ifdef PES_MULARB_PRIO0_EN
  // Requester 0 bypasses the rotation; only grants to 1..NREQ-1 move the pointer.
  assign rr_req = {bus.req_valid[NREQ-1:1], 1'b0};

  always_comb begin
    grant = rr_grant;
    gidx  = rr_idx;
    any   = rr_any;
    if (bus.req_valid[0]) begin
      grant = {{(NREQ-1){1'b0}}, 1'b1};
      gidx  = '0;
      any   = 1'b1;
    end
  end

  assign adv_ptr = hs && !bus.req_valid[0];
`else
  assign rr_req  = bus.req_valid;
  assign grant   = rr_grant;
  assign gidx    = rr_idx;
  assign any     = rr_any;
  assign adv_ptr = hs;
`endif

  // Grant only ever selects a valid requester, so any grant is a handshake.
  assign hs            = !rst && any;
  assign bus.req_ready = rst ? '0 : grant;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = bus.req_a[i*DATA_W +: DATA_W];
        sel_b = bus.req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg      <= '0;
      mul_a_reg    <= '0;
      mul_b_reg    <= '0;
      inflight_reg <= '0;
    end else begin
      if (hs) begin
        mul_a_reg <= sel_a;
        mul_b_reg <= sel_b;
      end
      if (adv_ptr) ptr_reg <= (gidx == TAG_W'(NREQ-1)) ? '0 : gidx + TAG_W'(1);
      case ({hs, rsp_hit})
        2'b10:   inflight_reg <= inflight_reg + INF_W'(1);
        2'b01:   inflight_reg <= inflight_reg - INF_W'(1);
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  // Stage 0 sits beside mul_a/mul_b; stages 1..MUL_LAT track the multiplier,
  // so the last stage lines up with mul_f.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= MUL_LAT; i++) tag_reg[i] <= '0;
    end else begin
      tag_reg[0] <= '{valid: hs, id: gidx};
      for (int i = 1; i <= MUL_LAT; i++) tag_reg[i] <= tag_reg[i-1];
    end
  end

  assign last    = tag_reg[MUL_LAT];
  assign rsp_hit = !rst && last.valid;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rsp
    assign rsp_vec[gi] = rsp_hit && (last.id == TAG_W'(gi));
  end

  assign bus.rsp_valid = rsp_vec;
  assign bus.rsp_data  = bus.mul_f;
  assign bus.mul_a     = mul_a_reg;
  assign bus.mul_b     = mul_b_reg;
  assign bus.inflight  = inflight_reg;

endmodule

// File: tb/tb_pes_mul_arbiter.sv
// Bench for pes_mul_arbiter: directed scenarios then random traffic, checked
// against a transaction-level model (grant rule + queue of expected products).
module tb_pes_mul_arbiter;
  import pes_mul_pkg::*;

  localparam int NREQ    = 4;
  localparam int DATA_W  = 32;
  localparam int MUL_LAT = 4;
  localparam int INF_W   = inflight_w(MUL_LAT);
`ifdef PES_MULARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  typedef struct {
    int                id;
    logic [DATA_W-1:0] data;
    int                due;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pes_mul_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) bus ();

  pes_mul_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Stand-in multiplier: samples mul_a/mul_b at an edge, result MUL_LAT edges later.
  logic [DATA_W-1:0] mp [MUL_LAT];
  always @(posedge clk) begin
    mp[0] <= bus.mul_a * bus.mul_b;
    for (int i = 1; i < MUL_LAT; i++) mp[i] <= mp[i-1];
  end
  assign bus.mul_f = mp[MUL_LAT-1];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ptr    = 0;
  int cur_g  = -1;
  int peak   = 0;
  logic [DATA_W-1:0] op_a [NREQ];
  logic [DATA_W-1:0] op_b [NREQ];
  logic [DATA_W-1:0] exp_ma = '0;
  logic [DATA_W-1:0] exp_mb = '0;
  rsp_t q [$];

  function automatic int calc_grant(input logic [NREQ-1:0] v, input int p);
    if (PRIO0 && v[0]) return 0;
    for (int o = 0; o < NREQ; o++) begin
      int j;
      j = (p + o) % NREQ;
      if (v[j] && !(PRIO0 && j == 0)) return j;
    end
    return -1;
  endfunction

  task automatic check_cycle();
    logic [NREQ-1:0]   exp_rdy, exp_rv;
    logic [DATA_W-1:0] exp_d;
    int                exp_inf;
    bit                pop;
    cur_g   = rst ? -1 : calc_grant(bus.req_valid, ptr);
    exp_rdy = '0;
    if (cur_g >= 0) exp_rdy[cur_g] = 1'b1;
    exp_rv  = '0;
    exp_d   = '0;
    pop     = 1'b0;
    exp_inf = q.size();
    if (!rst && q.size() > 0 && q[0].due == cyc) begin
      exp_rv[q[0].id] = 1'b1;
      exp_d = q[0].data;
      pop   = 1'b1;
    end
    checks++;
    assert (bus.req_ready === exp_rdy) else begin
      errors++;
      $error("FAIL req_ready cyc=%0d: got %b expected %b", cyc, bus.req_ready, exp_rdy);
    end
    checks++;
    assert (bus.rsp_valid === exp_rv) else begin
      errors++;
      $error("FAIL rsp_valid cyc=%0d: got %b expected %b", cyc, bus.rsp_valid, exp_rv);
    end
    if (pop) begin
      checks++;
      assert (bus.rsp_data === exp_d) else begin
        errors++;
        $error("FAIL rsp_data cyc=%0d: got %h expected %h", cyc, bus.rsp_data, exp_d);
      end
    end
    checks++;
    assert (bus.inflight === INF_W'(exp_inf)) else begin
      errors++;
      $error("FAIL inflight cyc=%0d: got %0d expected %0d", cyc, bus.inflight, exp_inf);
    end
    checks++;
    assert (bus.mul_a === exp_ma) else begin
      errors++;
      $error("FAIL mul_a cyc=%0d: got %h expected %h", cyc, bus.mul_a, exp_ma);
    end
    checks++;
    assert (bus.mul_b === exp_mb) else begin
      errors++;
      $error("FAIL mul_b cyc=%0d: got %h expected %h", cyc, bus.mul_b, exp_mb);
    end
    if (int'(bus.inflight) > peak) peak = int'(bus.inflight);
    if (pop) void'(q.pop_front());
  endtask

  task automatic advance();
    rsp_t r;
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      ptr    = 0;
      exp_ma = '0;
      exp_mb = '0;
    end else if (cur_g >= 0) begin
      r.id   = cur_g;
      r.data = op_a[cur_g] * op_b[cur_g];
      r.due  = cyc + MUL_LAT;
      q.push_back(r);
      exp_ma = op_a[cur_g];
      exp_mb = op_b[cur_g];
      if (!(PRIO0 && cur_g == 0)) ptr = (cur_g + 1) % NREQ;
    end
    #1;
  endtask

  task automatic step(input logic [NREQ-1:0] v, input logic r);
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*DATA_W +: DATA_W] = op_a[i];
      bus.req_b[i*DATA_W +: DATA_W] = op_b[i];
    end
    bus.req_valid = v;
    rst = r;
    @(negedge clk);
    check_cycle();
    $display("cyc=%0d rst=%b valid=%b ready=%b rsp_valid=%b rsp_data=%h inflight=%0d",
             cyc, rst, bus.req_valid, bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.inflight);
    advance();
  endtask

  task automatic drain();
    repeat (MUL_LAT + 2) step('0, 1'b0);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = DATA_W'(32'h11 * (i + 1));
      op_b[i] = DATA_W'(32'h3 + i);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset held with every requester asking
    repeat (3) step('1, 1'b1);

    // Single request from requester 0
    op_a[0] = 32'h10; op_b[0] = 32'h1;
    step(4'b0001, 1'b0);
    drain();

    // Round-robin with all requesters valid, from a fresh pointer
    step('0, 1'b1);
    op_a[0] = 32'hF0;   op_b[0] = 32'h40;
    op_a[1] = 32'hC000; op_b[1] = 32'h1000;
    op_a[2] = 32'hAA00; op_b[2] = 32'h100;
    op_a[3] = 32'h9000; op_b[3] = 32'h8000;
    peak = 0;
    repeat (8) step('1, 1'b0);
    drain();
    checks++;
    assert (peak == MUL_LAT + 1) else begin
      errors++;
      $error("FAIL inflight_peak: got %0d expected %0d", peak, MUL_LAT + 1);
    end

    // Requester 3 then requester 0 with an idle cycle between (pointer wrap)
    op_a[3] = 32'h30; op_b[3] = 32'h9;
    op_a[0] = 32'h20; op_b[0] = 32'h10;
    step(4'b1000, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0001, 1'b0);
    drain();

    // Reset while operations are in flight, then confirm pointer restarts at 0
    step('1, 1'b0);
    step('1, 1'b0);
    step('1, 1'b1);
    drain();
    step('1, 1'b0);
    drain();

`ifdef PES_MULARB_PRIO0_EN
    // Requester 0 starves the others until it drops
    repeat (6) step('1, 1'b0);
    repeat (6) step(4'b1110, 1'b0);
    drain();
`endif

    // Random traffic with occasional resets
    repeat (300) begin
      for (int i = 0; i < NREQ; i++) begin
        op_a[i] = ($urandom_range(0, 1) == 0) ? DATA_W'($urandom_range(0, 255)) : DATA_W'($urandom);
        op_b[i] = ($urandom_range(0, 1) == 0) ? DATA_W'($urandom_range(0, 255)) : DATA_W'($urandom);
      end
      step(NREQ'($urandom_range(0, (1 << NREQ) - 1)), ($urandom_range(0, 39) == 0));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
